// File: rtl/quadrature_input.sv
// Rotary-encoder front end: synchronises and debounces A/B and the push switch, then turns
// Gray-code steps into one-cycle up/down pulses per detent and a one-cycle button pulse.
module quadrature_input #(
    parameter int unsigned DEBOUNCE_CYCLES        = 2500,
    parameter int unsigned SWITCH_DEBOUNCE_CYCLES = 250000,
    parameter int unsigned STEPS_PER_DETENT       = 4
) (
    input  logic CLOCK_25,
    input  logic RESET_N,
    input  logic in_a,
    input  logic in_b,
    input  logic switch,
    output logic up,
    output logic down,
    output logic button
);

    localparam int unsigned AbCntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SwCntW =
        (SWITCH_DEBOUNCE_CYCLES > 1) ? $clog2(SWITCH_DEBOUNCE_CYCLES) : 1;
    localparam int unsigned AccW   = $clog2(STEPS_PER_DETENT) + 2;

    localparam logic [AbCntW-1:0]      AbCntMax = AbCntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SwCntW-1:0]      SwCntMax = SwCntW'(SWITCH_DEBOUNCE_CYCLES - 1);
    localparam logic signed [AccW-1:0] AccPos   = AccW'(STEPS_PER_DETENT);
    localparam logic signed [AccW-1:0] AccNeg   = -AccPos;

    // Bit order everywhere: {a, b, switch}
    logic [2:0] sync1_q, sync2_q;

    logic [1:0]             ab_db_q, ab_db_d;
    logic [1:0][AbCntW-1:0] ab_cnt_q, ab_cnt_d;
    logic [1:0]             ab_sync;

    logic              sw_db_q, sw_db_d;
    logic [SwCntW-1:0] sw_cnt_q, sw_cnt_d;
    logic              sw_prev_q;

    logic [1:0]            ab_prev_q;
    logic signed [AccW-1:0] acc_q, acc_d, acc_sum;
    logic                  step_cw, step_ccw;

    logic up_q, up_d;
    logic down_q, down_d;
    logic button_q, button_d;

    assign ab_sync = sync2_q[2:1];

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {in_a, in_b, switch};
            sync2_q <= sync1_q;
        end
    end

    // Counter runs only while the synced level disagrees with the accepted level.
    always_comb begin
        ab_db_d  = ab_db_q;
        ab_cnt_d = ab_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (ab_sync[i] == ab_db_q[i]) begin
                ab_cnt_d[i] = '0;
            end else if (ab_cnt_q[i] == AbCntMax) begin
                ab_db_d[i]  = ab_sync[i];
                ab_cnt_d[i] = '0;
            end else begin
                ab_cnt_d[i] = ab_cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        sw_db_d  = sw_db_q;
        sw_cnt_d = sw_cnt_q;
        if (sync2_q[0] == sw_db_q) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q == SwCntMax) begin
            sw_db_d  = sync2_q[0];
            sw_cnt_d = '0;
        end else begin
            sw_cnt_d = sw_cnt_q + 1'b1;
        end
    end

    always_comb begin
        step_cw  = 1'b0;
        step_ccw = 1'b0;
        case ({ab_prev_q, ab_db_q})
            4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: step_cw  = 1'b1;
            4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: step_ccw = 1'b1;
            default: ;
        endcase
    end

    // Landing on the rest state without a full detent realigns the count to zero.
    always_comb begin
        if (step_cw) begin
            acc_sum = acc_q + AccW'(1);
        end else if (step_ccw) begin
            acc_sum = acc_q - AccW'(1);
        end else begin
            acc_sum = acc_q;
        end
        acc_d  = acc_q;
        up_d   = 1'b0;
        down_d = 1'b0;
        if (step_cw || step_ccw) begin
            if (acc_sum == AccPos) begin
                up_d  = 1'b1;
                acc_d = '0;
            end else if (acc_sum == AccNeg) begin
                down_d = 1'b1;
                acc_d  = '0;
            end else if (ab_db_q == 2'b11) begin
                acc_d = '0;
            end else begin
                acc_d = acc_sum;
            end
        end
        button_d = sw_prev_q & ~sw_db_q;
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            ab_db_q   <= 2'b11;
            ab_cnt_q  <= '0;
            sw_db_q   <= 1'b1;
            sw_cnt_q  <= '0;
            sw_prev_q <= 1'b1;
            ab_prev_q <= 2'b11;
            acc_q     <= '0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            button_q  <= 1'b0;
        end else begin
            ab_db_q   <= ab_db_d;
            ab_cnt_q  <= ab_cnt_d;
            sw_db_q   <= sw_db_d;
            sw_cnt_q  <= sw_cnt_d;
            sw_prev_q <= sw_db_q;
            ab_prev_q <= ab_db_q;
            acc_q     <= acc_d;
            up_q      <= up_d;
            down_q    <= down_d;
            button_q  <= button_d;
        end
    end

    assign up     = up_q;
    assign down   = down_q;
    assign button = button_q;

endmodule

// File: tb/tb_quadrature_input.sv
// Bench for quadrature_input: directed encoder scenarios plus a random walk, all checked
// against a pin-history reference model through an expected-pulse scoreboard.
module tb_quadrature_input;

    localparam int unsigned DB  = 4;
    localparam int unsigned SWD = 8;
    localparam int          SPD = 4;

    logic clk = 1'b0;
    logic RESET_N;
    logic in_a, in_b, switch;
    logic up, down, button;

    quadrature_input #(
        .DEBOUNCE_CYCLES       (DB),
        .SWITCH_DEBOUNCE_CYCLES(SWD),
        .STEPS_PER_DETENT      (SPD)
    ) dut (
        .CLOCK_25(clk),
        .RESET_N (RESET_N),
        .in_a    (in_a),
        .in_b    (in_b),
        .switch  (switch),
        .up      (up),
        .down    (down),
        .button  (button)
    );

    initial forever #5 clk = ~clk;

    // Edge k of the clock happens at time 10k+5.
    function automatic int cyc_now();
        return int'(($time - 5) / 10);
    endfunction

    function automatic int pos_of(input logic [1:0] s);
        case (s)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p)
            0:       return 2'b11;
            1:       return 2'b01;
            2:       return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    typedef struct {
        int         cyc;
        int         ep;
        logic [2:0] mask;  // {up, down, button}
    } exp_t;

    exp_t exp_q[$];
    int   epoch = 0;

    // Stimulus-owned phase description
    int phase = 0;
    int p_up = 0, p_dn = 0, p_btn = 0;
    int ref_cyc = -1, lat_kind = 0, lat_exp = 0;
    bit done = 1'b0;

    // Reference model: a debounced level flips once the pin has shown the new level for
    // N consecutive samples (pins reach the debouncer two samples late); pulses land one
    // cycle after the debounced change that causes them.
    initial begin
        logic [2:0] hist[$];
        logic [2:0] db_m, old_db, new_db;
        int         acc, d, n, c;
        logic       v, ok;
        db_m = 3'b111;
        acc  = 0;
        forever begin
            @(posedge clk or negedge RESET_N);
            if (!RESET_N) begin
                epoch = epoch + 1;
                hist.delete();
                for (int i = 0; i < SWD + 2; i++) hist.push_back(3'b111);
                db_m = 3'b111;
                acc  = 0;
            end else begin
                c = cyc_now();
                hist.push_back({in_a, in_b, switch});
                void'(hist.pop_front());
                old_db = db_m;
                new_db = db_m;
                for (int ch = 0; ch < 3; ch++) begin
                    n  = (ch == 0) ? SWD : DB;
                    v  = hist[$-2][ch];
                    ok = 1'b1;
                    for (int m = 2; m <= n + 1; m++) if (hist[$-m][ch] != v) ok = 1'b0;
                    if (ok) new_db[ch] = v;
                end
                db_m = new_db;
                if (new_db[2:1] != old_db[2:1]) begin
                    d = (pos_of(new_db[2:1]) - pos_of(old_db[2:1]) + 4) % 4;
                    if (d != 2) begin
                        acc = acc + ((d == 1) ? 1 : -1);
                        if (acc == SPD) begin
                            exp_q.push_back('{cyc: c + 1, ep: epoch, mask: 3'b100});
                            acc = 0;
                        end else if (acc == -SPD) begin
                            exp_q.push_back('{cyc: c + 1, ep: epoch, mask: 3'b010});
                            acc = 0;
                        end else if (new_db[2:1] == 2'b11) begin
                            acc = 0;
                        end
                    end
                end
                if (old_db[0] && !new_db[0])
                    exp_q.push_back('{cyc: c + 1, ep: epoch, mask: 3'b001});
            end
        end
    end

    // Monitor / scoreboard
    int total = 0, bad = 0;
    int rd = 0;
    int cur_phase = 0;
    int sv_up = 0, sv_dn = 0, sv_btn = 0, sv_ref = -1, sv_lk = 0, sv_lat = 0;
    int n_up = 0, n_dn = 0, n_btn = 0, first_up = -1, first_btn = -1;

    task automatic check(input string name, input int act, input int want);
        total = total + 1;
        if (act != want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic eval_phase();
        if (sv_up >= 0)  check($sformatf("phase%0d up count", cur_phase), n_up, sv_up);
        if (sv_dn >= 0)  check($sformatf("phase%0d down count", cur_phase), n_dn, sv_dn);
        if (sv_btn >= 0) check($sformatf("phase%0d button count", cur_phase), n_btn, sv_btn);
        if (sv_lk == 1)
            check($sformatf("phase%0d up latency", cur_phase), first_up - sv_ref, sv_lat);
        if (sv_lk == 2)
            check($sformatf("phase%0d button latency", cur_phase), first_btn - sv_ref, sv_lat);
    endtask

    initial begin
        int         c, left;
        logic [2:0] e, a;
        forever begin
            @(negedge clk);
            c = cyc_now();
            if (phase != cur_phase) begin
                eval_phase();
                cur_phase = phase;
                n_up      = 0;
                n_dn      = 0;
                n_btn     = 0;
                first_up  = -1;
                first_btn = -1;
            end
            a = {up, down, button};
            if (!RESET_N) begin
                check("outputs quiet in reset", int'(a), 0);
            end else begin
                e = 3'b000;
                while (rd < exp_q.size() && (exp_q[rd].ep != epoch || exp_q[rd].cyc <= c)) begin
                    if (exp_q[rd].ep == epoch) begin
                        if (exp_q[rd].cyc < c) check("pulse missed, cycle", c, exp_q[rd].cyc);
                        else e = e | exp_q[rd].mask;
                    end
                    rd = rd + 1;
                end
                if (a != 3'b000 || e != 3'b000)
                    check($sformatf("pulses {up,down,button} at cycle %0d", c), int'(a), int'(e));
                if (up) begin
                    n_up = n_up + 1;
                    if (first_up < 0) first_up = c;
                end
                if (down) n_dn = n_dn + 1;
                if (button) begin
                    n_btn = n_btn + 1;
                    if (first_btn < 0) first_btn = c;
                end
            end
            sv_up  = p_up;
            sv_dn  = p_dn;
            sv_btn = p_btn;
            sv_ref = ref_cyc;
            sv_lk  = lat_kind;
            sv_lat = lat_exp;
            if (done || c > 30000) begin
                if (!done) check("run finished within cycle budget", c, 30000);
                left = 0;
                for (int i = rd; i < exp_q.size(); i++) if (exp_q[i].ep == epoch) left++;
                check("expected pulses never seen", left, 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    // Stimulus
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ab(input logic [1:0] v, input int n);
        {in_a, in_b} = v;
        tick(n);
    endtask

    task automatic begin_phase(input int id, input int eu, input int ed, input int eb,
                               input int lk, input int lat);
        p_up     = eu;
        p_dn     = ed;
        p_btn    = eb;
        ref_cyc  = -1;
        lat_kind = lk;
        lat_exp  = lat;
        phase    = id;
    endtask

    initial begin
        int pos, dir, ab_t, sw_t;
        in_a    = 1'b1;
        in_b    = 1'b1;
        switch  = 1'b1;
        RESET_N = 1'b0;
        tick(3);
        RESET_N = 1'b1;
        tick(10);

        // Clockwise detent
        begin_phase(1, 1, 0, 0, 1, 7);
        ab(2'b01, 20); ab(2'b00, 20); ab(2'b10, 20);
        ref_cyc = cyc_now();
        ab(2'b11, 20);

        // Counter-clockwise detent, then a partial turn that returns to rest
        begin_phase(2, 0, 1, 0, 0, 0);
        ab(2'b10, 20); ab(2'b00, 20); ab(2'b01, 20); ab(2'b11, 20);
        ab(2'b01, 20); ab(2'b00, 20); ab(2'b01, 20); ab(2'b11, 20);

        // Contact bounce on A shorter than the debounce window
        begin_phase(3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            ab(2'b01, 2);
            ab(2'b11, 2);
        end
        ab(2'b11, 20);

        // Both channels jump together, then finish only half a detent
        begin_phase(4, 0, 0, 0, 0, 0);
        ab(2'b00, 20); ab(2'b10, 20); ab(2'b11, 20);

        // Held press, release, then a glitch press
        begin_phase(5, 0, 0, 1, 2, 11);
        ref_cyc = cyc_now();
        switch  = 1'b0;
        tick(50);
        switch = 1'b1;
        tick(30);
        switch = 1'b0;
        tick(5);
        switch = 1'b1;
        tick(30);

        // Reset mid-detent, then a complete detent afterwards
        begin_phase(6, 1, 0, 0, 1, 7);
        ab(2'b01, 20); ab(2'b00, 20); ab(2'b10, 10);
        RESET_N = 1'b0;
        tick(5);
        RESET_N = 1'b1;
        tick(20);
        ab(2'b11, 20); ab(2'b01, 20); ab(2'b00, 20); ab(2'b10, 20);
        ref_cyc = cyc_now();
        ab(2'b11, 20);

        // Random walk with mixed hold times and random switch activity
        begin_phase(7, -1, -1, -1, 0, 0);
        pos  = 0;
        dir  = 1;
        ab_t = 0;
        sw_t = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ab_t == 0) begin
                if ($urandom_range(0, 9) == 0) dir = -dir;
                pos          = (pos + dir + 4) % 4;
                {in_a, in_b} = ab_of(pos);
                ab_t         = int'($urandom_range(1, 14));
            end else begin
                ab_t = ab_t - 1;
            end
            if (sw_t == 0) begin
                switch = ~switch;
                sw_t   = int'($urandom_range(1, 20));
            end else begin
                sw_t = sw_t - 1;
            end
            tick(1);
        end
        switch = 1'b1;
        ab(2'b11, 30);

        begin_phase(8, 0, 0, 0, 0, 0);
        tick(5);
        done = 1'b1;
        tick(10);
    end

endmodule
